lpm_exec_unit: RTL and testbench

//  Executes the LPM family (LPM; LPM Rd,Z; LPM Rd,Z+) for the ATmega32A core. Sits

---
 rtl/lpm_pkg.sv | 25 ++
 rtl/lpm_exec_unit.sv | 131 +++++++++++++
 tb/tb_lpm_exec_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpm_pkg.sv
// Shared encodings for the LPM execution unit: instruction modes, FSM states,
// fixed destination register and the byte-select helper.
// Purely declarative; no logic, no latency, no flow control.
package lpm_pkg;

  // lpm_mode encodings as decoded by the control unit
  localparam logic [1:0] LPM_R0      = 2'b00;  // LPM        -> R0
  localparam logic [1:0] LPM_RD      = 2'b01;  // LPM Rd,Z
  localparam logic [1:0] LPM_RD_ZINC = 2'b10;  // LPM Rd,Z+
  localparam logic [1:0] LPM_RSV     = 2'b11;  // reserved

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [4:0] R0_ADDR = 5'd0;

  // Z[0] selects the high byte of the program-memory word
  function automatic logic [7:0] pick_byte(input logic [15:0] word,
                                           input logic        hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/lpm_exec_unit.sv
// LPM / LPM Rd,Z / LPM Rd,Z+ executor: fetches program word Z>>1, writes the
// Z[0]-selected byte to the register file and optionally writes back Z+1.
// Latency: start edge -> pm_req next cycle; ack edge -> rf_we for one cycle.
// Backpressure: waits indefinitely in REQ for pm_ack; new starts while busy
// are dropped and flagged on err.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   lpm_enable          control-unit strobe (2 cycles per LPM; rising edge starts)
//   lpm_mode, rd_sel    instruction variant and destination register
//   z_in                current Z pointer (R31:R30)
//   pm_req/pm_addr      program-memory word read request / word address
//   pm_ack/pm_rdata     read completion and data
//   rf_we/rf_waddr/rf_wdata   register-file write port
//   z_we/z_wdata        Z pointer write-back (Z+ mode only)
//   busy, err           not-idle flag; 1-cycle error pulse
module lpm_exec_unit
  import lpm_pkg::*;
#(
  parameter int PM_ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lpm_enable,
  input  logic [1:0]           lpm_mode,
  input  logic [4:0]           rd_sel,
  input  logic [15:0]          z_in,
  output logic                 pm_req,
  output logic [PM_ADDR_W-1:0] pm_addr,
  input  logic                 pm_ack,
  input  logic [15:0]          pm_rdata,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [7:0]           rf_wdata,
  output logic                 z_we,
  output logic [15:0]          z_wdata,
  output logic                 busy,
  output logic                 err
);

  localparam logic [31:0] PM_WORDS = 32'd1 << PM_ADDR_W;

  logic [1:0]  state;
  logic        en_q;
  logic [1:0]  mode_q;
  logic [4:0]  dest_q;
  logic [15:0] z_q;

  logic start;
  logic bad_req;

  // Only the rising edge of the strobe starts an op; the second enable cycle
  // and a level-held enable look identical to "no start".
  assign start = lpm_enable & ~en_q;

  assign bad_req = (lpm_mode == LPM_RSV) ||
                   ({17'd0, z_in[15:1]} >= PM_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= LPM_R0;
      dest_q   <= R0_ADDR;
      z_q      <= '0;
      pm_req   <= 1'b0;
      pm_addr  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      z_we     <= 1'b0;
      z_wdata  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      en_q  <= lpm_enable;
      err   <= 1'b0;
      rf_we <= 1'b0;
      z_we  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (bad_req) begin
              err <= 1'b1;
            end else begin
              mode_q  <= lpm_mode;
              dest_q  <= (lpm_mode == LPM_R0) ? R0_ADDR : rd_sel;
              z_q     <= z_in;
              pm_req  <= 1'b1;
              pm_addr <= z_in[PM_ADDR_W:1];
              busy    <= 1'b1;
              state   <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (start) err <= 1'b1;
          // Byte capture and write launch share the ack edge so the write
          // strobe appears in the cycle right after the ack.
          if (pm_ack) begin
            pm_req   <= 1'b0;
            rf_we    <= 1'b1;
            rf_waddr <= dest_q;
            rf_wdata <= pick_byte(pm_rdata, z_q[0]);
            if (mode_q == LPM_RD_ZINC) begin
              z_we    <= 1'b1;
              z_wdata <= z_q + 16'd1;
            end
            state <= ST_WB;
          end
        end

        ST_WB: begin
          // A start landing on the completing edge is still an overrun.
          if (start) err <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          pm_req <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpm_exec_unit.sv
module tb_lpm_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lpm_enable = 1'b0;
  logic [1:0]  lpm_mode = 2'b00;
  logic [4:0]  rd_sel = 5'd0;
  logic [15:0] z_in = 16'h0000;
  logic [15:0] pm_rdata = 16'h0000;
  logic        force_ack = 1'b0;

  // index 0: PM_ADDR_W=14, index 1: PM_ADDR_W=15
  logic        ack[2] = '{1'b0, 1'b0};
  logic        pm_ack_w[2];
  logic        pm_req_w[2], rf_we_w[2], z_we_w[2], busy_w[2], err_w[2];
  logic [13:0] addr14;
  logic [14:0] addr15;
  logic [4:0]  waddr_w[2];
  logic [7:0]  wdata_w[2];
  logic [15:0] zwd_w[2];
  logic [15:0] a_addr[2];

  assign a_addr[0]   = {2'b00, addr14};
  assign a_addr[1]   = {1'b0, addr15};
  assign pm_ack_w[0] = ack[0] | force_ack;
  assign pm_ack_w[1] = ack[1] | force_ack;

  always #5 clk = ~clk;

  lpm_exec_unit #(.PM_ADDR_W(14)) u14 (
    .clk(clk), .reset(reset), .lpm_enable(lpm_enable), .lpm_mode(lpm_mode),
    .rd_sel(rd_sel), .z_in(z_in), .pm_req(pm_req_w[0]), .pm_addr(addr14),
    .pm_ack(pm_ack_w[0]), .pm_rdata(pm_rdata), .rf_we(rf_we_w[0]),
    .rf_waddr(waddr_w[0]), .rf_wdata(wdata_w[0]), .z_we(z_we_w[0]),
    .z_wdata(zwd_w[0]), .busy(busy_w[0]), .err(err_w[0]));

  lpm_exec_unit #(.PM_ADDR_W(15)) u15 (
    .clk(clk), .reset(reset), .lpm_enable(lpm_enable), .lpm_mode(lpm_mode),
    .rd_sel(rd_sel), .z_in(z_in), .pm_req(pm_req_w[1]), .pm_addr(addr15),
    .pm_ack(pm_ack_w[1]), .pm_rdata(pm_rdata), .rf_we(rf_we_w[1]),
    .rf_waddr(waddr_w[1]), .rf_wdata(wdata_w[1]), .z_we(z_we_w[1]),
    .z_wdata(zwd_w[1]), .busy(busy_w[1]), .err(err_w[1]));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s u%0d: got %h expected %h (cycle %0d)",
               nm, inst, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: ack after ack_delay extra cycles of pm_req.
  int ack_delay = 0;
  int wcnt[2] = '{0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset && pm_req_w[i] === 1'b1) begin
        if (wcnt[i] >= ack_delay) begin ack[i] = 1'b1; wcnt[i] = 0; end
        else begin ack[i] = 1'b0; wcnt[i]++; end
      end else begin
        ack[i] = 1'b0; wcnt[i] = 0;
      end
    end
  end

  // Behavioural model: one operation record per unit plus expected outputs.
  bit          m_prev[2], m_busy[2], m_req[2], m_we[2], m_zwe[2], m_err[2];
  logic [15:0] m_addr[2], m_zwd[2], m_z[2];
  logic [7:0]  m_wdata[2];
  logic [4:0]  m_waddr[2], m_dest[2];
  logic [1:0]  m_mode[2];
  int          mw[2] = '{14, 15};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit st, was_busy;
      if (reset) begin
        m_prev[i] = 0; m_busy[i] = 0; m_req[i] = 0; m_we[i] = 0;
        m_zwe[i] = 0; m_err[i] = 0; m_addr[i] = 0; m_zwd[i] = 0;
        m_wdata[i] = 0; m_waddr[i] = 0;
      end else begin
        st = lpm_enable && !m_prev[i];
        m_prev[i] = lpm_enable;
        was_busy = m_busy[i];
        m_err[i] = st && was_busy;
        if (was_busy && m_we[i]) begin
          m_we[i] = 0; m_zwe[i] = 0; m_busy[i] = 0;
        end else if (was_busy) begin
          if (pm_ack_w[i]) begin
            m_req[i]   = 0;
            m_we[i]    = 1;
            m_waddr[i] = m_dest[i];
            m_wdata[i] = m_z[i][0] ? pm_rdata[15:8] : pm_rdata[7:0];
            if (m_mode[i] == 2'b10) begin
              m_zwe[i] = 1;
              m_zwd[i] = m_z[i] + 16'd1;
            end
          end
        end else if (st) begin
          if (lpm_mode == 2'b11 || int'(z_in >> 1) >= (1 << mw[i])) begin
            m_err[i] = 1;
          end else begin
            m_busy[i] = 1; m_req[i] = 1;
            m_addr[i] = z_in >> 1;
            m_dest[i] = (lpm_mode == 2'b00) ? 5'd0 : rd_sel;
            m_z[i]    = z_in;
            m_mode[i] = lpm_mode;
          end
        end
      end
    end
  end

  // Per-cycle comparison plus event monitor.
  int wr_cnt[2] = '{0, 0}, err_cnt[2] = '{0, 0}, req_cnt[2] = '{0, 0};
  int w_cyc[2];
  logic [7:0]  lw_data[2];
  logic [4:0]  lw_addr[2];
  logic        lw_zwe[2];
  logic [15:0] lw_zd[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (chk_on) begin
        chk("pm_req", i, 32'(pm_req_w[i]), 32'(m_req[i]));
        chk("pm_addr", i, 32'(a_addr[i]), 32'(m_addr[i]));
        chk("rf_we", i, 32'(rf_we_w[i]), 32'(m_we[i]));
        chk("rf_waddr", i, 32'(waddr_w[i]), 32'(m_waddr[i]));
        chk("rf_wdata", i, 32'(wdata_w[i]), 32'(m_wdata[i]));
        chk("z_we", i, 32'(z_we_w[i]), 32'(m_zwe[i]));
        chk("z_wdata", i, 32'(zwd_w[i]), 32'(m_zwd[i]));
        chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
        chk("err", i, 32'(err_w[i]), 32'(m_err[i]));
      end
      if (rf_we_w[i] === 1'b1) begin
        wr_cnt[i]++; w_cyc[i] = cyc;
        lw_data[i] = wdata_w[i]; lw_addr[i] = waddr_w[i];
        lw_zwe[i] = z_we_w[i]; lw_zd[i] = zwd_w[i];
      end
      if (err_w[i] === 1'b1) err_cnt[i]++;
      if (pm_req_w[i] === 1'b1) req_cnt[i]++;
    end
  end

  int b_wr[2], b_err[2], b_req[2];
  int start_cyc;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_wr[i] = wr_cnt[i]; b_err[i] = err_cnt[i]; b_req[i] = req_cnt[i];
    end
  endtask

  task automatic op(input logic [1:0] m, input logic [4:0] rd,
                    input logic [15:0] z, input logic [15:0] rdat,
                    input int dly, input int en_len);
    snap();
    pm_rdata = rdat; ack_delay = dly;
    lpm_mode = m; rd_sel = rd; z_in = z; lpm_enable = 1'b1;
    tick(1);
    start_cyc = cyc;
    if (en_len > 1) tick(en_len - 1);
    lpm_enable = 1'b0;
    tick(dly + 4);
  endtask

  initial begin
    tick(2);
    chk_on = 1'b1;
    tick(1);
    // reset state
    chk("rst_pm_req", 0, 32'(pm_req_w[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("rst_zwdata", 1, 32'(zwd_w[1]), 32'd0);
    chk("rst_addr", 0, 32'(addr14), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: mode 00, zero-wait memory, high byte
    op(2'b00, 5'd7, 16'h0101, 16'hBEEF, 0, 2);
    chk("t1_addr", 0, 32'(addr14), 32'h0080);
    chk("t1_waddr", 0, 32'(lw_addr[0]), 32'd0);
    chk("t1_wdata", 0, 32'(lw_data[0]), 32'hBE);
    chk("t1_zwe", 0, 32'(lw_zwe[0]), 32'd0);
    chk("t1_latency", 0, 32'(w_cyc[0] - start_cyc), 32'd1);
    chk("t1_writes", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd1);

    // 2: mode 10, Z wraps; only the 15-bit unit can reach word 0x7FFF
    op(2'b10, 5'd5, 16'hFFFF, 16'h1234, 0, 2);
    chk("t2_wdata", 1, 32'(lw_data[1]), 32'h12);
    chk("t2_waddr", 1, 32'(lw_addr[1]), 32'd5);
    chk("t2_zwe", 1, 32'(lw_zwe[1]), 32'd1);
    chk("t2_zwdata", 1, 32'(lw_zd[1]), 32'h0000);
    chk("t2_range_err", 0, 32'(err_cnt[0] - b_err[0]), 32'd1);
    chk("t2_range_nowr", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd0);

    // 3: mode 01, ack delayed 4 cycles, low byte
    op(2'b01, 5'd17, 16'h0042, 16'hA55A, 4, 2);
    chk("t3_req_cycles", 0, 32'(req_cnt[0] - b_req[0]), 32'd5);
    chk("t3_writes", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd1);
    chk("t3_wdata", 0, 32'(lw_data[0]), 32'h5A);
    chk("t3_waddr", 0, 32'(lw_addr[0]), 32'd17);

    // 4: Z beyond 16K words on the 14-bit unit
    op(2'b01, 5'd3, 16'h8000, 16'h00FF, 0, 2);
    chk("t4_err", 0, 32'(err_cnt[0] - b_err[0]), 32'd1);
    chk("t4_noreq", 0, 32'(req_cnt[0] - b_req[0]), 32'd0);
    chk("t4_nowr", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd0);
    chk("t4_ok15", 1, 32'(wr_cnt[1] - b_wr[1]), 32'd1);

    // reserved mode
    op(2'b11, 5'd9, 16'h0010, 16'h1111, 0, 2);
    chk("rsv_err", 1, 32'(err_cnt[1] - b_err[1]), 32'd1);
    chk("rsv_nowr", 1, 32'(wr_cnt[1] - b_wr[1]), 32'd0);

    // level-held enable starts exactly one op
    op(2'b01, 5'd2, 16'h0020, 16'hC3D4, 0, 6);
    chk("lvl_writes", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd1);
    chk("lvl_noerr", 0, 32'(err_cnt[0] - b_err[0]), 32'd0);

    // 5: second rising enable while in REQ
    snap();
    pm_rdata = 16'h7788; ack_delay = 3;
    lpm_mode = 2'b01; rd_sel = 5'd3; z_in = 16'h0100; lpm_enable = 1'b1;
    tick(2);
    lpm_enable = 1'b0;
    tick(1);
    rd_sel = 5'd9; z_in = 16'h0201; lpm_enable = 1'b1;
    tick(2);
    lpm_enable = 1'b0;
    tick(6);
    chk("t5_err", 0, 32'(err_cnt[0] - b_err[0]), 32'd1);
    chk("t5_writes", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd1);
    chk("t5_waddr", 0, 32'(lw_addr[0]), 32'd3);
    chk("t5_wdata", 0, 32'(lw_data[0]), 32'h88);

    // start landing on the WB cycle is an overrun
    snap();
    pm_rdata = 16'h0F0E; ack_delay = 0;
    lpm_mode = 2'b10; rd_sel = 5'd20; z_in = 16'h1234; lpm_enable = 1'b1;
    tick(1);
    lpm_enable = 1'b0;
    tick(1);
    lpm_enable = 1'b1;
    tick(1);
    lpm_enable = 1'b0;
    tick(4);
    chk("wb_ovr_err", 0, 32'(err_cnt[0] - b_err[0]), 32'd1);
    chk("wb_ovr_writes", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd1);
    chk("wb_ovr_zwd", 0, 32'(lw_zd[0]), 32'h1235);

    // 6: reset while waiting in REQ, then a stray ack
    snap();
    ack_delay = 1000;
    lpm_mode = 2'b10; rd_sel = 5'd4; z_in = 16'h0300; lpm_enable = 1'b1;
    tick(2);
    lpm_enable = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    force_ack = 1'b1;
    tick(1);
    force_ack = 1'b0;
    tick(3);
    chk("t6_nowr", 0, 32'(wr_cnt[0] - b_wr[0]), 32'd0);
    chk("t6_nowr", 1, 32'(wr_cnt[1] - b_wr[1]), 32'd0);
    chk("t6_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("t6_req", 1, 32'(pm_req_w[1]), 32'd0);
    chk("t6_addr", 0, 32'(addr14), 32'd0);
    ack_delay = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
